// File: rtl/mix_columns_iter.sv
// Forward AES MixColumns, iterative: COLS_PER_CYCLE columns per clock through shared GF(2^8) units.
// A 128-bit state is accepted on a valid/ready handshake and held on state_out until consumed.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] state_out,
    output logic         busy
);

    // Handshake rule (both sides): a transfer happens on a rising edge where valid
    // and ready are both high; the sender holds data stable until that edge.

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    logic [1:0]   col_cnt_q;
    logic [1:0]   col_cnt_d;
    logic [0:127] in_buf_q;
    logic [0:127] res_q;
    logic [0:127] res_d;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;
    logic         last_grp;

    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One column unit: a0 is the most significant byte (row 0).
    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    assign last_grp  = (col_cnt_q == LAST_COL);
    assign col_cnt_d = last_grp ? 2'd0 : col_cnt_q + STEP;

    // col_cnt is always a multiple of COLS_PER_CYCLE, so the unit offsets never wrap.
    always_comb begin
        res_d = res_q;
        for (int u = 0; u < COLS_PER_CYCLE; u++) begin
            col_idx[u] = col_cnt_q + 2'(u);
            col_out[u] = mix_col(in_buf_q[32*col_idx[u] +: 32]);
            res_d[32*col_idx[u] +: 32] = col_out[u];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            col_cnt_q   <= 2'd0;
            in_buf_q    <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_buf_q   <= state_in;
                        col_cnt_q  <= 2'd0;
                        state_q    <= CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                CALC: begin
                    res_q     <= res_d;
                    col_cnt_q <= col_cnt_d;
                    if (last_grp) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = res_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter: one instance per legal COLS_PER_CYCLE (1, 2, 4)
// sharing clock and reset, with hand-computed vectors and an inverse-MixColumns round trip.
module tb_mix_columns_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic         busy      [3];
    logic [0:127] state_in  [3];
    logic [0:127] state_out [3];

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] V_FIPS = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] E_FIPS = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] V2     = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;
    localparam logic [127:0] E2     = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
    localparam logic [127:0] V3     = 128'h01010101_d4d4d4d5_db135345_f20a225c;
    localparam logic [127:0] E3     = 128'h01010101_d5d5d7d6_8e4da1bc_9fdc589d;

    mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .state_in(state_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .state_out(state_out[0]),
        .busy(busy[0])
    );

    mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .state_in(state_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .state_out(state_out[1]),
        .busy(busy[1])
    );

    mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .state_in(state_in[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .state_out(state_out[2]),
        .busy(busy[2])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 1;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Inverse MixColumns, used only to check that each result maps back to its input.
    function automatic logic [0:127] inv_mix(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c + 8 +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            r[32*c +: 8]      = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
            r[32*c + 8 +: 8]  = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
            r[32*c + 16 +: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
            r[32*c + 24 +: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
        end
        return r;
    endfunction

    // Accept one state, measure edges from accept to out_valid, check result; leaves DUT in DONE.
    task automatic run_vec(input int k, input logic [0:127] din, input logic [0:127] exp_v,
                           input string name);
        int n;
        bit seen;
        @(negedge clk);
        n_vec++;
        if (in_ready[k] !== 1'b1) begin
            n_err++;
            $display("FAIL %s[%0d] in_ready before accept: got %b want 1", name, k, in_ready[k]);
        end
        in_valid[k] = 1'b1;
        state_in[k] = din;
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                in_valid[k] = 1'b0;
                state_in[k] = '0;
            end
            if (out_valid[k] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        n_vec++;
        if (!seen || n != lat_of(k)) begin
            n_err++;
            $display("FAIL %s[%0d] latency: got %0d (seen=%0b) want %0d", name, k, n, seen, lat_of(k));
        end
        n_vec++;
        if (state_out[k] !== exp_v) begin
            n_err++;
            $display("FAIL %s[%0d] state_out: got %h want %h", name, k, state_out[k], exp_v);
        end
        n_vec++;
        if (inv_mix(state_out[k]) !== din) begin
            n_err++;
            $display("FAIL %s[%0d] round trip: got %h want %h", name, k, inv_mix(state_out[k]), din);
        end
    endtask

    // Complete the output handshake; result must persist after out_valid drops.
    task automatic handshake(input int k, input logic [0:127] exp_v, input string name);
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
        n_vec++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0 || state_out[k] !== exp_v) begin
            n_err++;
            $display("FAIL %s[%0d] after handshake: got ov=%b ir=%b busy=%b out=%h want ov=0 ir=1 busy=0 out=%h",
                     name, k, out_valid[k], in_ready[k], busy[k], state_out[k], exp_v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            state_in[k]  = '0;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0 || state_out[k] !== 128'h0) begin
                n_err++;
                $display("FAIL reset[%0d]: got ov=%b ir=%b busy=%b out=%h want 0 1 0 0",
                         k, out_valid[k], in_ready[k], busy[k], state_out[k]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset[%0d]: got ov=%b ir=%b busy=%b want 0 1 0",
                         k, out_valid[k], in_ready[k], busy[k]);
            end
        end
    endtask

    task automatic test_fips();
        run_vec(0, V_FIPS, E_FIPS, "fips");
        handshake(0, E_FIPS, "fips");
    endtask

    task automatic test_columns();
        for (int k = 0; k < 3; k++) begin
            run_vec(k, V2, E2, "cols_a");
            handshake(k, E2, "cols_a");
            run_vec(k, V3, E3, "cols_b");
            handshake(k, E3, "cols_b");
        end
    endtask

    task automatic test_backpressure(input int k);
        run_vec(k, V2, E2, "bp");
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                in_valid[k] = 1'b1;
                state_in[k] = V3;
            end
            if (c == 5) begin
                in_valid[k] = 1'b0;
                state_in[k] = '0;
            end
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0 || busy[k] !== 1'b1 || state_out[k] !== E2) begin
                n_err++;
                $display("FAIL bp_hold[%0d] cyc %0d: got ov=%b ir=%b busy=%b out=%h want 1 0 1 %h",
                         k, c, out_valid[k], in_ready[k], busy[k], state_out[k], E2);
            end
        end
        handshake(k, E2, "bp");
    endtask

    task automatic test_back_to_back(input int k);
        logic [127:0] exp_q[$];
        logic [127:0] e;
        int acc[2];
        int na;
        int no;
        exp_q.push_back(E2);
        exp_q.push_back(E3);
        na = 0;
        no = 0;
        acc[0] = 0;
        acc[1] = 0;
        out_ready[k] = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            in_valid[k] = (na < 2);
            state_in[k] = (na == 0) ? V2 : V3;
            if (out_valid[k] === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b[%0d] extra output: got %h want none", k, state_out[k]);
                end else begin
                    e = exp_q.pop_front();
                    if (state_out[k] !== e) begin
                        n_err++;
                        $display("FAIL b2b[%0d] result %0d: got %h want %h", k, no, state_out[k], e);
                    end
                end
                no++;
            end
            if (in_valid[k] && in_ready[k] === 1'b1 && na < 2) begin
                acc[na] = cyc;
                na++;
            end
            if (na == 2 && no == 2) break;
        end
        in_valid[k] = 1'b0;
        state_in[k] = '0;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
        n_vec++;
        if (na != 2 || no != 2) begin
            n_err++;
            $display("FAIL b2b[%0d] timeout: got accepts=%0d outputs=%0d want 2 2", k, na, no);
        end
        n_vec++;
        if (acc[1] - acc[0] != lat_of(k) + 2) begin
            n_err++;
            $display("FAIL b2b[%0d] accept spacing: got %0d want %0d", k, acc[1] - acc[0], lat_of(k) + 2);
        end
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        in_valid[0] = 1'b1;
        state_in[0] = V3;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_vec++;
        if (busy[0] !== 1'b1 || state_out[0] === 128'h0) begin
            n_err++;
            $display("FAIL mid_calc_pre: got busy=%b out=%h want busy=1 out nonzero", busy[0], state_out[0]);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || state_out[0] !== 128'h0) begin
            n_err++;
            $display("FAIL mid_calc_rst: got ov=%b busy=%b out=%h want 0 0 0", out_valid[0], busy[0], state_out[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || state_out[0] !== 128'h0) begin
            n_err++;
            $display("FAIL mid_calc_release: got ir=%b ov=%b busy=%b out=%h want 1 0 0 0",
                     in_ready[0], out_valid[0], busy[0], state_out[0]);
        end
        run_vec(0, V2, E2, "after_rst");
        handshake(0, E2, "after_rst");
    endtask

    initial begin
        test_reset();
        test_fips();
        test_columns();
        test_backpressure(0);
        test_backpressure(2);
        for (int k = 0; k < 3; k++) test_back_to_back(k);
        test_reset_mid_calc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
